// File: rtl/axi_node_dec_pkg.sv
// Shared types and helpers for the AXI node address decoders.
package axi_node_dec_pkg;

    typedef enum logic [1:0] {
        OPERATIVE           = 2'd0,
        COMPLETE_PENDING    = 2'd1,
        ACCEPT_WDATA        = 2'd2,
        COMPLETE_ERROR_RESP = 2'd3
    } dec_state_t;

    // Bits needed to hold 0..max_outstanding inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/axi_aw_decoder_ordered_if.sv
// AW request, routing and error-handshake bundle between the target side and the decoder.
interface axi_aw_decoder_ordered_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned N_INIT_PORT = 8
);
    logic                   awvalid_i;
    logic [ADDR_WIDTH-1:0]  awaddr_i;
    logic                   awready_o;
    logic [N_INIT_PORT-1:0] awvalid_o;
    logic [N_INIT_PORT-1:0] awready_i;
    logic                   grant_FIFO_DEST_i;
    logic [N_INIT_PORT-1:0] DEST_o;
    logic                   push_DEST_o;
    logic                   b_done_i;
    logic                   error_req_o;
    logic                   error_gnt_i;
    logic                   handle_error_o;
    logic                   wdata_error_completed_i;
    logic                   sample_awdata_info_o;

    modport slave (
        input  awvalid_i, awaddr_i, awready_i, grant_FIFO_DEST_i, b_done_i,
               error_gnt_i, wdata_error_completed_i,
        output awready_o, awvalid_o, DEST_o, push_DEST_o, error_req_o,
               handle_error_o, sample_awdata_info_o
    );

    modport master (
        output awvalid_i, awaddr_i, awready_i, grant_FIFO_DEST_i, b_done_i,
               error_gnt_i, wdata_error_completed_i,
        input  awready_o, awvalid_o, DEST_o, push_DEST_o, error_req_o,
               handle_error_o, sample_awdata_info_o
    );
endinterface

// File: rtl/axi_region_match.sv
// Region compare, connectivity mask and lowest-index priority encode (shared with AR decoder).
module axi_region_match #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned N_INIT_PORT = 8,
    parameter int unsigned N_REGION    = 2
) (
    input  logic [ADDR_WIDTH-1:0]                                addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] start_addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] end_addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable,
    input  logic [N_INIT_PORT-1:0]                               connectivity,
    output logic [N_INIT_PORT-1:0]                               hit,
    output logic                                                 no_match
);

    logic [N_INIT_PORT-1:0] raw;

    // Per-port hit: any enabled region containing the address, then reachability mask.
    always_comb begin
        raw = '0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            for (int r = 0; r < N_REGION; r++) begin
                if (enable[r][p] && (addr >= start_addr[r][p]) && (addr <= end_addr[r][p])) begin
                    raw[p] = 1'b1;
                end
            end
        end
        raw = raw & connectivity;
    end

    // Lowest index wins so the result is one-hot or zero.
    always_comb begin
        hit = '0;
        for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
            if (raw[p]) begin
                hit = N_INIT_PORT'(1) << p;
            end
        end
    end

    assign no_match = ~|raw;

endmodule

// File: rtl/axi_aw_decoder_ordered.sv
// AW decoder with same-destination ordering via an internal outstanding counter.
// Define AXI_AW_DEC_DEFAULT_PORT_EN to route unmapped AWs to DEFAULT_PORT instead
// of running the error sequence.
module axi_aw_decoder_ordered
    import axi_node_dec_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned N_INIT_PORT     = 8,
    parameter int unsigned N_REGION        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned DEFAULT_PORT    = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    axi_aw_decoder_ordered_if.slave                              bus,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
    input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]                outstanding_o
);

    localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

    logic [N_INIT_PORT-1:0] hit;
    logic                   no_match;
    logic [N_INIT_PORT-1:0] dest;
    logic                   mapped;
    logic                   may_issue;
    logic                   err_accept;
    logic                   handshake;
    logic                   b_dec;
    logic [CNT_W-1:0]       cnt_q;
    logic [N_INIT_PORT-1:0] last_dest_q;
    dec_state_t             state_q;
    dec_state_t             state_d;
    logic                   handle_c;
    logic                   err_req_c;

    axi_region_match #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .N_INIT_PORT (N_INIT_PORT),
        .N_REGION    (N_REGION)
    ) u_match (
        .addr         (bus.awaddr_i),
        .start_addr   (START_ADDR_i),
        .end_addr     (END_ADDR_i),
        .enable       (enable_region_i),
        .connectivity (connectivity_map_i),
        .hit          (hit),
        .no_match     (no_match)
    );

`ifdef AXI_AW_DEC_DEFAULT_PORT_EN
    localparam logic [N_INIT_PORT-1:0] DEFAULT_ONEHOT = N_INIT_PORT'(1) << DEFAULT_PORT;
    assign dest   = no_match ? DEFAULT_ONEHOT : hit;
    assign mapped = 1'b1;
    logic unused_err_inputs;
    assign unused_err_inputs = bus.wdata_error_completed_i ^ bus.error_gnt_i;
`else
    assign dest   = hit;
    assign mapped = ~no_match;
    logic unused_default_port;
    assign unused_default_port = ^32'(DEFAULT_PORT);
`endif

    // Issue/accept decision; uses registered count so a same-cycle B never unblocks.
    always_comb begin
        may_issue  = 1'b0;
        err_accept = 1'b0;
        if (bus.awvalid_i && (state_q == OPERATIVE) && bus.grant_FIFO_DEST_i) begin
            if (mapped) begin
                may_issue = (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                            ((cnt_q == '0) || (dest == last_dest_q));
            end else begin
                err_accept = 1'b1;
            end
        end
    end

    assign handshake       = may_issue && (|(bus.awready_i & dest));
    assign b_dec           = bus.b_done_i && (cnt_q != '0);
    assign bus.awvalid_o   = may_issue ? dest : '0;
    assign bus.awready_o   = may_issue ? (|(bus.awready_i & dest)) : err_accept;
    assign bus.push_DEST_o = handshake;
    assign bus.DEST_o      = bus.awvalid_i ? dest : '0;
    assign outstanding_o   = rst ? '0 : cnt_q;

    // Outstanding counter and last issued destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            last_dest_q <= '0;
        end else begin
            if (handshake) begin
                last_dest_q <= dest;
            end
            if (handshake && !b_dec) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!handshake && b_dec) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Error FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OPERATIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Error FSM next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        handle_c  = 1'b0;
        err_req_c = 1'b0;
`ifndef AXI_AW_DEC_DEFAULT_PORT_EN
        case (state_q)
            OPERATIVE: begin
                if (err_accept) state_d = COMPLETE_PENDING;
            end
            COMPLETE_PENDING: begin
                if (cnt_q == '0) state_d = ACCEPT_WDATA;
            end
            ACCEPT_WDATA: begin
                handle_c = 1'b1;
                if (bus.wdata_error_completed_i) state_d = COMPLETE_ERROR_RESP;
            end
            COMPLETE_ERROR_RESP: begin
                err_req_c = 1'b1;
                if (bus.error_gnt_i) state_d = OPERATIVE;
            end
            default: state_d = OPERATIVE;
        endcase
`endif
    end

`ifdef AXI_AW_DEC_DEFAULT_PORT_EN
    assign bus.handle_error_o       = 1'b0;
    assign bus.error_req_o          = 1'b0;
    assign bus.sample_awdata_info_o = 1'b0;
    logic unused_fsm;
    assign unused_fsm = handle_c ^ err_req_c ^ err_accept;
`else
    assign bus.handle_error_o       = handle_c && !rst;
    assign bus.error_req_o          = err_req_c && !rst;
    assign bus.sample_awdata_info_o = err_accept;
`endif

endmodule

// File: tb/tb_axi_aw_decoder_ordered.sv
// Randomized + directed bench for axi_aw_decoder_ordered against a behavioural model.
module tb_axi_aw_decoder_ordered;

    localparam int unsigned AW    = 32;
    localparam int unsigned NP    = 8;
    localparam int unsigned NR    = 2;
    localparam int unsigned MAXO  = 4;
    localparam int unsigned DEFP  = 7;
    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0][NP-1:0][AW-1:0] start_addr;
    logic [NR-1:0][NP-1:0][AW-1:0] end_addr;
    logic [NR-1:0][NP-1:0]         en;
    logic [NP-1:0]                 conn;
    logic [CNT_W-1:0]              outstanding;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: outstanding writes, last issued port, error phase
    // (0 idle, 1 draining, 2 sinking W, 3 awaiting error grant).
    int m_cnt   = 0;
    int m_last  = -1;
    int m_phase = 0;
    int sticky_port = 0;

    axi_aw_decoder_ordered_if #(.ADDR_WIDTH(AW), .N_INIT_PORT(NP)) bus ();

    axi_aw_decoder_ordered #(
        .ADDR_WIDTH      (AW),
        .N_INIT_PORT     (NP),
        .N_REGION        (NR),
        .MAX_OUTSTANDING (MAXO),
        .DEFAULT_PORT    (DEFP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .START_ADDR_i       (start_addr),
        .END_ADDR_i         (end_addr),
        .enable_region_i    (en),
        .connectivity_map_i (conn),
        .outstanding_o      (outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // First port (lowest index) whose enabled region contains a, or -1.
    function automatic int decode(input logic [AW-1:0] a);
        for (int p = 0; p < NP; p++) begin
            if (conn[p]) begin
                for (int r = 0; r < NR; r++) begin
                    if (en[r][p] && a >= start_addr[r][p] && a <= end_addr[r][p]) return p;
                end
            end
        end
        return -1;
    endfunction

    // Compare outputs with the model, then advance the model across the clock edge.
    task automatic run_cycle();
        int tgt;
        bit unm, issue, err_acc, hs, bdec;
        logic [NP-1:0] exp_aw, exp_dest;
        #1;
        tgt = decode(bus.awaddr_i);
        unm = (tgt < 0);
`ifdef AXI_AW_DEC_DEFAULT_PORT_EN
        if (unm) begin
            tgt = int'(DEFP);
            unm = 1'b0;
        end
`endif
        issue = bus.awvalid_i && !unm && m_phase == 0 && bus.grant_FIFO_DEST_i &&
                m_cnt < int'(MAXO) && (m_cnt == 0 || tgt == m_last);
`ifdef AXI_AW_DEC_DEFAULT_PORT_EN
        err_acc = 1'b0;
`else
        err_acc = bus.awvalid_i && unm && m_phase == 0 && bus.grant_FIFO_DEST_i;
`endif
        hs = issue && bus.awready_i[tgt];
        exp_aw   = issue ? (NP'(1) << tgt) : '0;
        exp_dest = (bus.awvalid_i && tgt >= 0) ? (NP'(1) << tgt) : '0;
        if (rst) begin
            check("rst_awvalid_o", 64'(bus.awvalid_o), 64'h0);
            check("rst_awready_o", 64'(bus.awready_o), 64'h0);
            check("rst_push", 64'(bus.push_DEST_o), 64'h0);
            check("rst_handle", 64'(bus.handle_error_o), 64'h0);
            check("rst_err_req", 64'(bus.error_req_o), 64'h0);
            check("rst_outstanding", 64'(outstanding), 64'h0);
        end else begin
            check("awvalid_o", 64'(bus.awvalid_o), 64'(exp_aw));
            check("awready_o", 64'(bus.awready_o), 64'(issue ? bus.awready_i[tgt] : err_acc));
            check("push_DEST_o", 64'(bus.push_DEST_o), 64'(hs));
            check("DEST_o", 64'(bus.DEST_o), 64'(exp_dest));
            check("sample_awdata_info_o", 64'(bus.sample_awdata_info_o), 64'(err_acc));
            check("handle_error_o", 64'(bus.handle_error_o), 64'(m_phase == 2));
            check("error_req_o", 64'(bus.error_req_o), 64'(m_phase == 3));
            check("outstanding_o", 64'(outstanding), 64'(m_cnt));
        end
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            m_last = -1;
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (err_acc) m_phase = 1;
                1: if (m_cnt == 0) m_phase = 2;
                2: if (bus.wdata_error_completed_i) m_phase = 3;
                default: if (bus.error_gnt_i) m_phase = 0;
            endcase
            bdec = bus.b_done_i && m_cnt > 0;
            if (hs) m_last = tgt;
            if (hs && !bdec) m_cnt++;
            else if (!hs && bdec) m_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.awvalid_i = 1'b0;
        bus.awaddr_i = '0;
        bus.awready_i = '1;
        bus.grant_FIFO_DEST_i = 1'b1;
        bus.b_done_i = 1'b0;
        bus.error_gnt_i = 1'b0;
        bus.wdata_error_completed_i = 1'b0;
    endtask

    task automatic aw(input logic [AW-1:0] a);
        bus.awvalid_i = 1'b1;
        bus.awaddr_i = a;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 3) == 0) sticky_port = $urandom_range(0, 6);
        case (k)
            0, 1, 2, 3: return 32'h2000_0000 + 32'(sticky_port) * 32'h0100_0000 + 32'($urandom_range(0, 32'hFFFF));
            4: return start_addr[0][sticky_port];
            5: return end_addr[0][sticky_port];
            6: return 32'h1000_0000 + 32'($urandom_range(0, 32'h1FFF));
            7: return 32'h2700_0000;
            8: return 32'h1FFF_FFFF;
            default: return 32'($urandom());
        endcase
    endfunction

    initial begin
        start_addr = '0;
        end_addr = '0;
        en = '0;
        conn = '1;
        for (int p = 0; p < 7; p++) begin
            start_addr[0][p] = 32'h2000_0000 + 32'(p) * 32'h0100_0000;
            end_addr[0][p]   = start_addr[0][p] + 32'h00FF_FFFF;
            en[0][p]         = 1'b1;
        end
        start_addr[1][2] = 32'h1000_0000; end_addr[1][2] = 32'h1000_0FFF; en[1][2] = 1'b1;
        start_addr[1][5] = 32'h1000_0000; end_addr[1][5] = 32'h1000_00FF; en[1][5] = 1'b1;

        idle();
        rst = 1'b1;
        @(negedge clk);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        check("post_rst_outstanding", 64'(outstanding), 64'h0);
        check("post_rst_handle", 64'(bus.handle_error_o), 64'h0);
        run_cycle();

        // Overlapping regions: port 2 beats port 5.
        aw(32'h1000_0040);
        #1;
        check("ovl_dest", 64'(bus.DEST_o), 64'h04);
        check("ovl_push", 64'(bus.push_DEST_o), 64'h1);
        run_cycle();
        check("ovl_cnt", 64'(outstanding), 64'h1);
        idle(); bus.b_done_i = 1'b1; run_cycle(); idle();

        // Ordering stall: outstanding to port 1 blocks port 3.
        aw(32'h2100_0000); run_cycle();
        aw(32'h2300_0010);
        #1;
        check("ord_stall", 64'(bus.awvalid_o), 64'h0);
        run_cycle(); run_cycle();
        bus.b_done_i = 1'b1;
        #1;
        check("ord_stall_bdone", 64'(bus.awvalid_o), 64'h0);
        run_cycle();
        bus.b_done_i = 1'b0;
        #1;
        check("ord_issue", 64'(bus.awvalid_o), 64'h08);
        run_cycle();
        check("ord_cnt", 64'(outstanding), 64'h1);
        idle(); bus.b_done_i = 1'b1; run_cycle(); idle();

        // Full: four to port 0, fifth stalls even with a same-cycle B.
        aw(32'h2000_0100);
        repeat (4) run_cycle();
        #1;
        check("full_cnt", 64'(outstanding), 64'h4);
        check("full_stall", 64'(bus.awvalid_o), 64'h0);
        run_cycle();
        bus.b_done_i = 1'b1;
        #1;
        check("full_stall_bdone", 64'(bus.awvalid_o), 64'h0);
        run_cycle();
        #1;
        check("full_hs_with_bdone", 64'(bus.awvalid_o), 64'h01);
        run_cycle();
        check("full_keep_cnt", 64'(outstanding), 64'h3);
        bus.b_done_i = 1'b0;
        run_cycle();
        check("full_refill", 64'(outstanding), 64'h4);
        idle(); bus.b_done_i = 1'b1; run_cycle(); run_cycle(); idle();

`ifdef AXI_AW_DEC_DEFAULT_PORT_EN
        idle(); bus.b_done_i = 1'b1; run_cycle(); run_cycle(); idle();
        aw(32'h0000_1000);
        #1;
        check("dflt_awvalid", 64'(bus.awvalid_o), 64'h80);
        check("dflt_no_sample", 64'(bus.sample_awdata_info_o), 64'h0);
        run_cycle();
        check("dflt_no_handle", 64'(bus.handle_error_o), 64'h0);
        idle(); bus.b_done_i = 1'b1; run_cycle(); idle();
`else
        // Error sequence with two writes outstanding.
        check("err_pre_cnt", 64'(outstanding), 64'h2);
        aw(32'h0000_1000);
        #1;
        check("err_awready", 64'(bus.awready_o), 64'h1);
        check("err_sample", 64'(bus.sample_awdata_info_o), 64'h1);
        check("err_no_awvalid", 64'(bus.awvalid_o), 64'h0);
        check("err_no_push", 64'(bus.push_DEST_o), 64'h0);
        run_cycle();
        #1;
        check("err_no_accept", 64'(bus.awready_o), 64'h0);
        run_cycle();
        idle(); bus.b_done_i = 1'b1; run_cycle(); run_cycle(); bus.b_done_i = 1'b0;
        check("err_pending", 64'(bus.handle_error_o), 64'h0);
        run_cycle();
        check("err_wdata", 64'(bus.handle_error_o), 64'h1);
        run_cycle();
        bus.wdata_error_completed_i = 1'b1; run_cycle(); bus.wdata_error_completed_i = 1'b0;
        check("err_req", 64'(bus.error_req_o), 64'h1);
        check("err_req_handle_off", 64'(bus.handle_error_o), 64'h0);
        run_cycle();
        bus.error_gnt_i = 1'b1; run_cycle(); bus.error_gnt_i = 1'b0;
        check("err_req_done", 64'(bus.error_req_o), 64'h0);
        aw(32'h2000_0000);
        #1;
        check("err_back_operative", 64'(bus.awvalid_o), 64'h01);
        run_cycle();
        idle(); bus.b_done_i = 1'b1; run_cycle(); idle();

        // Reset while sinking error W data.
        aw(32'h0000_2000); run_cycle(); idle(); run_cycle();
        check("rst_seq_handle_pre", 64'(bus.handle_error_o), 64'h1);
        rst = 1'b1; run_cycle(); rst = 1'b0;
        check("rst_seq_handle", 64'(bus.handle_error_o), 64'h0);
        check("rst_seq_outstanding", 64'(outstanding), 64'h0);
        run_cycle();
        check("rst_seq_no_err_req", 64'(bus.error_req_o), 64'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) conn = ($urandom_range(0, 1) == 0) ? '1 : NP'($urandom());
            rst = ($urandom_range(0, 199) == 0);
            bus.awvalid_i = rst ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.awaddr_i = rand_addr();
            bus.awready_i = ($urandom_range(0, 1) == 0) ? '1 : NP'($urandom());
            bus.grant_FIFO_DEST_i = ($urandom_range(0, 7) != 0);
            bus.b_done_i = ($urandom_range(0, 2) == 0);
            bus.wdata_error_completed_i = ($urandom_range(0, 2) == 0);
            bus.error_gnt_i = ($urandom_range(0, 2) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
